// File: rtl/sample_acq_sequencer.sv
// Periodic multi-channel ADC acquisition sequencer with an Avalon-MM register file.
// A shadow bank fills channel by channel and is copied atomically into the visible bank.
module sample_acq_sequencer #(
    parameter int NUM_CH = 6,
    parameter int DATA_W = 16,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              adc_req,
    output logic [2:0]        adc_ch,
    input  logic              adc_ack,
    input  logic [DATA_W-1:0] adc_data,
    output logic              new_sample,
    output logic              irq
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_STORE, S_DONE} state_t;

    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

    state_t            state_reg, state_next;
    logic              enable_reg, irq_en_reg;
    logic [DIV_W-1:0]  divider_reg, count_reg;
    logic [2:0]        chsel_reg, ch_reg;
    logic              new_sample_reg, overrun_reg;
    logic [31:0]       readdata_reg;
    logic [DATA_W-1:0] shadow_reg  [NUM_CH];
    logic [DATA_W-1:0] visible_reg [NUM_CH];

    logic                           tick, busy;
    logic                           wr_ctrl, wr_div, wr_status, wr_chsel;
    logic                           ns_set, ov_set, ns_clr, ov_clr;
    logic [NUM_CH-1:0][DATA_W-1:0]  data_terms;
    logic [DATA_W-1:0]              data_or;
    logic [31:0]                    read_mux;
    logic                           unused_wdata;

    assign wr_ctrl   = write && (address == 3'd0);
    assign wr_div    = write && (address == 3'd1);
    assign wr_status = write && (address == 3'd2);
    assign wr_chsel  = write && (address == 3'd3);
    assign unused_wdata = ^writedata;

    // Tick on the DIVIDER-to-0 wrap; a DIVIDER write restarts the period instead.
    assign tick = enable_reg && !wr_div && (count_reg == divider_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (wr_div || !enable_reg || (count_reg == divider_reg)) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (tick) state_next = S_REQ;
            S_REQ:   if (adc_ack) state_next = S_STORE;
            S_STORE: state_next = (ch_reg == LAST_CH) ? S_DONE : S_REQ;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        adc_req = (state_reg == S_REQ);
        busy    = (state_reg != S_IDLE);
    end

    assign adc_ch = ch_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_reg <= '0;
        end else if ((state_reg == S_IDLE) && tick) begin
            ch_reg <= '0;
        end else if ((state_reg == S_STORE) && (ch_reg != LAST_CH)) begin
            ch_reg <= ch_reg + 3'd1;
        end
    end

    // adc_data is only valid alongside adc_ack, so the sample is latched on the ack
    // and the STORE cycle just advances the channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_reg[i]  <= '0;
                visible_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((state_reg == S_REQ) && adc_ack && (ch_reg == 3'(i))) begin
                    shadow_reg[i] <= adc_data;
                end
                if (state_reg == S_DONE) begin
                    visible_reg[i] <= shadow_reg[i];
                end
            end
        end
    end

    // Hardware set takes priority over a simultaneous write-1-to-clear.
    assign ns_set = (state_reg == S_DONE);
    assign ov_set = ((state_reg == S_DONE) && new_sample_reg) || (tick && (state_reg != S_IDLE));
    assign ns_clr = wr_status && writedata[0];
    assign ov_clr = wr_status && writedata[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_reg     <= 1'b0;
            irq_en_reg     <= 1'b0;
            divider_reg    <= '0;
            chsel_reg      <= '0;
            new_sample_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                enable_reg <= writedata[0];
                irq_en_reg <= writedata[1];
            end
            if (wr_div) begin
                divider_reg <= writedata[DIV_W-1:0];
            end
            if (wr_chsel) begin
                chsel_reg <= writedata[2:0];
            end
            new_sample_reg <= ns_set || (new_sample_reg && !ns_clr);
            overrun_reg    <= ov_set || (overrun_reg && !ov_clr);
        end
    end

    // Out-of-range CHSEL matches no term, so DATA reads 0.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_data_sel
        assign data_terms[gi] = (chsel_reg == 3'(gi)) ? visible_reg[gi] : '0;
    end

    always_comb begin
        data_or = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            data_or = data_or | data_terms[i];
        end
    end

    always_comb begin
        read_mux = '0;
        case (address)
            3'd0:    read_mux = {30'd0, irq_en_reg, enable_reg};
            3'd1:    read_mux = 32'(divider_reg);
            3'd2:    read_mux = {29'd0, busy, overrun_reg, new_sample_reg};
            3'd3:    read_mux = {29'd0, chsel_reg};
            3'd4:    read_mux = 32'(data_or);
            default: read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg <= '0;
        end else if (read) begin
            readdata_reg <= read_mux;
        end
    end

    assign readdata   = readdata_reg;
    assign new_sample = new_sample_reg;
    assign irq        = new_sample_reg && irq_en_reg;

endmodule

// File: tb/tb_sample_acq_sequencer.sv
// Directed bench for sample_acq_sequencer: register map, frame sequencing, W1C, overrun and reset.
module tb_sample_acq_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address;
    logic        read, write;
    logic [31:0] writedata, readdata;
    logic        adc_req, adc_ack, new_sample, irq;
    logic [2:0]  adc_ch;
    logic [15:0] adc_data;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   ack_delay = 3;
    logic spur_ack = 1'b0;
    logic [15:0] spur_data = '0;
    int   start_cyc[$];

    sample_acq_sequencer #(.NUM_CH(6), .DATA_W(16), .DIV_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .adc_req(adc_req), .adc_ch(adc_ch),
        .adc_ack(adc_ack), .adc_data(adc_data), .new_sample(new_sample), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: ack ack_delay cycles after req, data = ch*0x100 + 5.
    initial begin : adc_model
        int wait_cnt;
        wait_cnt = 0;
        adc_ack = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            adc_ack  = spur_ack;
            adc_data = spur_ack ? spur_data : 16'h0000;
            if (adc_req) begin
                if (wait_cnt == ack_delay - 1) begin
                    adc_ack  = 1'b1;
                    adc_data = 16'(adc_ch) * 16'h0100 + 16'h0005;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Records the cycle at which each frame's first request appears.
    initial begin : frame_mon
        logic req_prev;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (adc_req && !req_prev && (adc_ch == 3'd0)) start_cyc.push_back(cyc);
            req_prev = adc_req;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    initial begin : main
        logic [31:0] rd;
        int n, bad, fs0;
        address = '0; read = 1'b0; write = 1'b0; writedata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_adc_req", 32'(adc_req), 32'd0);
        reset_n = 1'b1;
        check_eq("rst_readdata", readdata, 32'd0);
        check_eq("rst_new_sample", 32'(new_sample), 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_adc_ch", 32'(adc_ch), 32'd0);
        bus_read(3'd0, rd); check_eq("rst_ctrl", rd, 32'd0);
        bus_read(3'd1, rd); check_eq("rst_divider", rd, 32'd0);
        bus_read(3'd2, rd); check_eq("rst_status", rd, 32'd0);

        // Spurious ack in IDLE, unmapped addresses, out-of-range CHSEL
        @(posedge clk); #1 spur_ack = 1'b1; spur_data = 16'hBEEF;
        @(posedge clk); #1 spur_ack = 1'b0;
        repeat (2) @(negedge clk);
        bus_read(3'd2, rd); check_eq("spur_status", rd, 32'd0);
        bus_read(3'd4, rd); check_eq("spur_data_ch0", rd, 32'd0);
        bus_read(3'd6, rd); check_eq("addr6_read", rd, 32'd0);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd0, rd); check_eq("addr6_write_ignored", rd, 32'd0);
        bus_write(3'd3, 32'd7);
        bus_read(3'd3, rd); check_eq("chsel_rw", rd, 32'd7);
        bus_read(3'd4, rd); check_eq("chsel7_data", rd, 32'd0);

        // Normal frame: DIVIDER=99, ack delay 3
        fs0 = start_cyc.size();
        bus_write(3'd1, 32'd99);
        bus_read(3'd1, rd); check_eq("divider_rw", rd, 32'd99);
        bus_write(3'd0, 32'd3);
        n = 0;
        while (!new_sample && n < 400) begin @(negedge clk); #1; n++; end
        check_eq("A_new_sample", 32'(new_sample), 32'd1);
        check_eq("A_irq", 32'(irq), 32'd1);
        for (int c = 0; c < 6; c++) begin
            bus_write(3'd3, 32'(c));
            bus_read(3'd4, rd);
            check_eq($sformatf("A_data_ch%0d", c), rd, 32'(c * 256 + 5));
        end
        repeat (3) @(negedge clk);
        check_eq("A_readdata_hold", readdata, 32'h0505);
        bus_read(3'd2, rd); check_eq("A_status", rd, 32'd1);
        bus_write(3'd2, 32'd1);
        check_eq("A_w1c_new_sample", 32'(new_sample), 32'd0);
        check_eq("A_w1c_irq", 32'(irq), 32'd0);
        n = 0;
        while (start_cyc.size() < fs0 + 2 && n < 200) begin @(negedge clk); #1; n++; end
        check_eq("A_two_frames", 32'(start_cyc.size() - fs0), 32'd2);
        if (start_cyc.size() >= fs0 + 2)
            check_eq("A_period", 32'(start_cyc[fs0 + 1] - start_cyc[fs0]), 32'd100);
        // Disable mid-frame: frame completes, no further frames
        bus_write(3'd0, 32'd2);
        n = 0;
        while (!new_sample && n < 100) begin @(negedge clk); #1; n++; end
        check_eq("A_frame2_done", 32'(new_sample), 32'd1);
        repeat (250) @(negedge clk);
        check_eq("A_no_more_frames", 32'(start_cyc.size() - fs0), 32'd2);
        bus_read(3'd2, rd); check_eq("A_status_no_overrun", rd, 32'd1);

        // W1C in the DONE cycle loses to the hardware set
        bus_write(3'd2, 32'd3);
        bus_write(3'd0, 32'd1);
        n = 0;
        while (!(adc_ack && adc_ch == 3'd5) && n < 400) begin @(negedge clk); #1; n++; end
        check_eq("B_last_ack", 32'(adc_ack && adc_ch == 3'd5), 32'd1);
        @(negedge clk); #1;
        check_eq("B_req_low_in_store", 32'(adc_req), 32'd0);
        @(negedge clk);
        address = 3'd2; writedata = 32'd1; write = 1'b1;
        @(posedge clk); #1 write = 1'b0;
        check_eq("B_w1c_in_done", 32'(new_sample), 32'd1);
        bus_write(3'd0, 32'd0);
        bus_read(3'd2, rd); check_eq("B_status", rd, 32'd1);

        // Overrun: DIVIDER=3 with ack delay 10
        bus_write(3'd2, 32'd3);
        ack_delay = 10;
        fs0 = start_cyc.size();
        bus_write(3'd1, 32'd3);
        bus_write(3'd0, 32'd1);
        repeat (30) @(negedge clk);
        bus_read(3'd2, rd); check_eq("C_status_mid", rd, 32'd6);
        bus_write(3'd0, 32'd0);
        bad = 0; rd = '0; n = 0;
        while (rd[0] == 1'b0 && n < 200) begin
            bus_read(3'd2, rd);
            if (!rd[0] && !rd[2]) bad++;
            n++;
        end
        check_eq("C_busy_held", 32'(bad), 32'd0);
        check_eq("C_status_end", rd, 32'd3);
        check_eq("C_one_frame", 32'(start_cyc.size() - fs0), 32'd1);
        bus_write(3'd3, 32'd3);
        bus_read(3'd4, rd); check_eq("C_data_ch3", rd, 32'h0305);

        // Reset asserted while in REQ
        bus_write(3'd2, 32'd3);
        ack_delay = 3;
        bus_write(3'd1, 32'd5);
        bus_write(3'd0, 32'd3);
        n = 0;
        while (!adc_req && n < 50) begin @(negedge clk); #1; n++; end
        check_eq("D_in_req", 32'(adc_req), 32'd1);
        #1 reset_n = 1'b0;
        #1 check_eq("D_async_req", 32'(adc_req), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check_eq("D_readdata", readdata, 32'd0);
        check_eq("D_new_sample", 32'(new_sample), 32'd0);
        bus_read(3'd0, rd); check_eq("D_ctrl", rd, 32'd0);
        bus_read(3'd1, rd); check_eq("D_divider", rd, 32'd0);
        bus_read(3'd2, rd); check_eq("D_status", rd, 32'd0);
        bus_read(3'd3, rd); check_eq("D_chsel", rd, 32'd0);
        bus_read(3'd4, rd); check_eq("D_visible_ch0", rd, 32'd0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (adc_req) bad++;
        end
        check_eq("D_idle_after_reset", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sample_acq_sequencer.md
SAMPLE_ACQ_SEQUENCER -- requirements
Module: sample_acq_sequencer

Interface
REQ-001 Parameter NUM_CH, default 6: channels per frame (Va, Vb, Vc, Ia, Ib, Ic), range 1..8.
REQ-002 Parameter DATA_W, default 16: ADC sample width.
REQ-003 Parameter DIV_W, default 16: sample-period counter width.
REQ-004 clk  in  1  system clock.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 address  in  3  Avalon-MM slave word address.
REQ-007 read  in  1  Avalon read strobe.
REQ-008 write  in  1  Avalon write strobe.
REQ-009 writedata  in  32  Avalon write data.
REQ-010 readdata  out  32  Avalon read data, registered.
REQ-011 adc_req  out  1  conversion request to ADC interface.
REQ-012 adc_ch  out  3  channel index for the current request.
REQ-013 adc_ack  in  1  single-cycle completion strobe; adc_data valid in the same cycle.
REQ-014 adc_data  in  DATA_W  conversion result.
REQ-015 new_sample  out  1  frame-ready flag, equal to STATUS bit0.
REQ-016 irq  out  1  interrupt, equal to new_sample AND CTRL.irq_en.

Function
REQ-017 Register map SHALL be:
- 0 CTRL: bit0 enable, bit1 irq_en; R/W.
- 1 DIVIDER: sample period minus 1, DIV_W bits; R/W.
- 2 STATUS: bit0 new_sample, bit1 overrun, bit2 busy; bits 0-1 write-1-to-clear, bit2 read-only.
- 3 CHSEL: channel index, 3 bits; R/W.
- 4 DATA: visible-bank sample for CHSEL, zero-extended; read-only.
- Addresses 5-7 read 0; writes to them are ignored.
REQ-018 readdata SHALL update on the clock edge following a read, giving 1-cycle read latency; it holds its value while read is low.
REQ-019 When enable=1, a period counter SHALL count 0..DIVIDER and emit a one-cycle tick on the DIVIDER-to-0 wrap, giving one tick every DIVIDER+1 cycles.
REQ-020 When enable=0, the period counter SHALL be held at 0 and SHALL emit no ticks.
REQ-021 A DIVIDER write SHALL reset the period counter to 0.
REQ-022 FSM states SHALL be IDLE, REQ, STORE, DONE, with these transitions:
- IDLE: a tick sets ch=0 and moves to REQ.
- REQ: adc_req=1 and adc_ch=ch; on adc_ack, move to STORE.
- STORE: capture adc_data into shadow[ch]; if ch=NUM_CH-1, move to DONE; otherwise increment ch and return to REQ.
- DONE: move to IDLE after one cycle.
REQ-023 adc_req SHALL deassert for exactly the STORE cycle between channels.
REQ-024 adc_req SHALL be 0 in every state except REQ.
REQ-025 In DONE, all shadow entries SHALL copy atomically into the visible bank in one cycle, and new_sample SHALL be set.
REQ-026 If new_sample is already 1 on entry to DONE, overrun SHALL be set as well.
REQ-027 A tick arriving in any state other than IDLE SHALL be dropped and SHALL set overrun.
REQ-028 busy SHALL be 1 in REQ, STORE and DONE.
REQ-029 When a W1C write clears a flag in the same cycle that hardware sets it, the set SHALL win.
REQ-030 Clearing enable mid-frame SHALL let the current frame complete and SHALL block new ticks.
REQ-031 adc_ack SHALL be ignored in every state except REQ.
REQ-032 A CHSEL value of NUM_CH or greater SHALL make DATA read 0.

Reset
REQ-033 On reset_n=0, all of the following SHALL be 0: CTRL, DIVIDER, CHSEL, STATUS, period counter, ch, shadow bank, visible bank, readdata, adc_req, adc_ch, new_sample and irq.
REQ-034 On reset_n=0, the FSM SHALL return to IDLE.
REQ-035 Assertion of reset_n mid-frame SHALL abort the frame immediately, with no bank update.

Verification
REQ-036 DIVIDER=99, enable=1, ADC acks 3 cycles after each req with data=ch*0x100+5 -> ticks every 100 cycles; after frame, DATA for CHSEL=0..5 reads 0x0005, 0x0105 ... 0x0505; new_sample=1.
REQ-037 Frame completes with new_sample=1 and irq_en=1 -> irq=1; write STATUS=0x1 -> new_sample=0 and irq=0 the next cycle.
REQ-038 DIVIDER=3 with ack delay 10 -> overrun=1, the extra ticks are dropped, and busy stays 1 until frame end.
REQ-039 W1C of bit0 issued in the DONE cycle -> new_sample stays 1.
REQ-040 reset_n pulsed low while in REQ -> adc_req=0 asynchronously, all registers 0, visible bank unchanged at 0.
REQ-041 Spurious adc_ack in IDLE, plus reads of address 6 and of CHSEL=7 -> no state change, readdata=0.
